mdu_ctrl: RTL and testbench

- Multiply/divide unit controller and iterative datapath for the MIPS core. It owns the HI/LO registers.
- Sequences MULT/MULTU/DIV/DIVU over multiple cycles, one bit per cycle.
- Serves MFHI/MFLO/MTHI/MTLO from the execute stage.
- Raises a stall to the pipeline while an operation is in flight.

---
 rtl/mdu_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_mdu_ctrl.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_ctrl.sv
// mdu_ctrl: multiply/divide controller and iterative datapath; owns HI/LO.
//
// MULT/MULTU use shift-add over a 2*DATA_W accumulator, DIV/DIVU use
// restoring division. Both work on magnitudes for one bit per CALC cycle,
// then a single FIX cycle applies the result signs and writes HI/LO.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   issue_vld/issue_op   request: 0=MULT 1=MULTU 2=DIV 3=DIVU
//   rs_val, rt_val       multiplicand/dividend, multiplier/divisor
//   mf_req, mf_sel       MFHI/MFLO request; mf_sel 0=LO 1=HI (also for MT)
//   mf_data              combinational HI/LO read, meaningful when stall=0
//   mt_vld, mt_data      MTHI/MTLO write, taken only while idle
//   flush                abort: back to IDLE, HI/LO untouched, no accept
//   busy, stall          op in flight; execute must hold
//   div_zero             sticky flag for the last accepted divide
//   dbg_state            current FSM state (IDLE=0, CALC=1, FIX=2)
//
// Handshake: a request (issue/mf/mt) is consumed on a rising edge only
// while busy=0; while busy=1 stall is raised combinationally and the
// requester must hold its request until stall drops.
//
// Optional build macro MDU_EARLY_OUT_EN: multiply CALC stops as soon as
// no multiplier bits remain (minimum 1 cycle). Divide is unaffected.
module mdu_ctrl #(
  parameter int                DATA_W   = 32,
  parameter logic [DATA_W-1:0] HILO_RST = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              issue_vld,
  input  logic [1:0]        issue_op,
  input  logic [DATA_W-1:0] rs_val,
  input  logic [DATA_W-1:0] rt_val,
  input  logic              mf_req,
  input  logic              mf_sel,
  output logic [DATA_W-1:0] mf_data,
  input  logic              mt_vld,
  input  logic [DATA_W-1:0] mt_data,
  input  logic              flush,
  output logic              busy,
  output logic              stall,
  output logic              div_zero,
  output logic [1:0]        dbg_state
);

  localparam int CNT_W = $clog2(DATA_W) + 1;

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, FIX = 2'd2} state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_W-1:0]     hi_q, hi_d, lo_q, lo_d;
  // Multiply: acc = running product. Divide: acc = {remainder, dividend/quotient}.
  logic [2*DATA_W-1:0]   acc_q, acc_d;
  // Multiply: shifted multiplicand. Divide: divisor in the low half.
  logic [2*DATA_W-1:0]   mcand_q, mcand_d;
  logic [DATA_W-1:0]     mplier_q, mplier_d;
  logic                  is_div_q, is_div_d;
  logic                  neg_q, neg_d;     // product / quotient negative
  logic                  rneg_q, rneg_d;   // remainder negative
  logic                  div_zero_q, div_zero_d;

  logic                  signed_op, rs_neg, rt_neg;
  logic [DATA_W-1:0]     rs_mag, rt_mag;
  logic [DATA_W:0]       rem_sh;
  logic [DATA_W-1:0]     rem_sub;
  logic                  div_ge;
  logic                  last_calc;
  logic [2*DATA_W-1:0]   prod_fix;
  logic [DATA_W-1:0]     quot_fix, rem_fix;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    acc_d      = acc_q;
    mcand_d    = mcand_q;
    mplier_d   = mplier_q;
    is_div_d   = is_div_q;
    neg_d      = neg_q;
    rneg_d     = rneg_q;
    div_zero_d = div_zero_q;

    signed_op = ~issue_op[0];
    rs_neg    = signed_op & rs_val[DATA_W-1];
    rt_neg    = signed_op & rt_val[DATA_W-1];
    rs_mag    = rs_neg ? -rs_val : rs_val;
    rt_mag    = rt_neg ? -rt_val : rt_val;

    // One restoring-division step: shift the next dividend bit into the
    // remainder and subtract the divisor if it fits.
    rem_sh  = {acc_q[2*DATA_W-1:DATA_W], acc_q[DATA_W-1]};
    div_ge  = rem_sh >= {1'b0, mcand_q[DATA_W-1:0]};
    rem_sub = rem_sh[DATA_W-1:0] - mcand_q[DATA_W-1:0];

    last_calc = (cnt_q == CNT_W'(DATA_W - 1));
`ifdef MDU_EARLY_OUT_EN
    // Bits already consumed are shifted out, so once the multiplier's
    // upper bits are zero this is the last bit that can add anything.
    if (!is_div_q && (mplier_q[DATA_W-1:1] == '0)) last_calc = 1'b1;
`endif

    prod_fix = neg_q  ? -acc_q                   : acc_q;
    quot_fix = neg_q  ? -acc_q[DATA_W-1:0]        : acc_q[DATA_W-1:0];
    rem_fix  = rneg_q ? -acc_q[2*DATA_W-1:DATA_W] : acc_q[2*DATA_W-1:DATA_W];

    if (flush) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (issue_vld) begin
            state_d  = CALC;
            cnt_d    = '0;
            is_div_d = issue_op[1];
            neg_d    = rs_neg ^ rt_neg;
            rneg_d   = rs_neg;
            if (issue_op[1]) begin
              acc_d      = {{DATA_W{1'b0}}, rs_mag};
              mcand_d    = {{DATA_W{1'b0}}, rt_mag};
              div_zero_d = (rt_val == '0);
            end else begin
              acc_d    = '0;
              mcand_d  = {{DATA_W{1'b0}}, rs_mag};
              mplier_d = rt_mag;
            end
          end else if (mt_vld) begin
            if (mf_sel) hi_d = mt_data;
            else        lo_d = mt_data;
          end
        end
        CALC: begin
          cnt_d = cnt_q + 1'b1;
          if (is_div_q) begin
            acc_d = div_ge ? {rem_sub, acc_q[DATA_W-2:0], 1'b1}
                           : {acc_q[2*DATA_W-2:0], 1'b0};
          end else begin
            if (mplier_q[0]) acc_d = acc_q + mcand_q;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
          end
          if (last_calc) state_d = FIX;
        end
        FIX: begin
          state_d = IDLE;
          if (is_div_q) begin
            hi_d = rem_fix;
            lo_d = quot_fix;
          end else begin
            hi_d = prod_fix[2*DATA_W-1:DATA_W];
            lo_d = prod_fix[DATA_W-1:0];
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      hi_q       <= HILO_RST;
      lo_q       <= HILO_RST;
      acc_q      <= '0;
      mcand_q    <= '0;
      mplier_q   <= '0;
      is_div_q   <= 1'b0;
      neg_q      <= 1'b0;
      rneg_q     <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      acc_q      <= acc_d;
      mcand_q    <= mcand_d;
      mplier_q   <= mplier_d;
      is_div_q   <= is_div_d;
      neg_q      <= neg_d;
      rneg_q     <= rneg_d;
      div_zero_q <= div_zero_d;
    end
  end

  assign busy      = (state_q != IDLE);
  assign stall     = busy & (issue_vld | mf_req | mt_vld);
  assign mf_data   = mf_sel ? hi_q : lo_q;
  assign div_zero  = div_zero_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Bench for mdu_ctrl: arithmetic reference model plus per-cycle compare,
// directed vectors with literal expectations.
module tb_mdu_ctrl;

  localparam int          W     = 32;
  localparam logic [W-1:0] RST_V = '0;

  // ---------------- clock / reset / DUT ----------------
  logic         clk = 1'b0;
  logic         rst;
  logic         issue_vld;
  logic [1:0]   issue_op;
  logic [W-1:0] rs_val, rt_val;
  logic         mf_req, mf_sel;
  logic [W-1:0] mf_data;
  logic         mt_vld;
  logic [W-1:0] mt_data;
  logic         flush, busy, stall, div_zero;
  logic [1:0]   dbg_state;

  always #5 clk = ~clk;

  mdu_ctrl #(.DATA_W(W), .HILO_RST(RST_V)) dut (
    .clk(clk), .rst(rst),
    .issue_vld(issue_vld), .issue_op(issue_op),
    .rs_val(rs_val), .rt_val(rt_val),
    .mf_req(mf_req), .mf_sel(mf_sel), .mf_data(mf_data),
    .mt_vld(mt_vld), .mt_data(mt_data),
    .flush(flush), .busy(busy), .stall(stall), .div_zero(div_zero),
    .dbg_state(dbg_state)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit started  = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [W-1:0] m_hi = RST_V, m_lo = RST_V;
  int           m_busy = 0;
  logic         m_dz = 1'b0;
  logic [63:0]  exp_q[$];   // {HI, LO} of the op in flight

  function automatic logic [63:0] model_result(input logic [1:0] op,
                                               input logic [W-1:0] a,
                                               input logic [W-1:0] b);
    longint sa, sb, p, q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      2'd0: begin p = sa * sb; return 64'(p); end
      2'd1: return {32'b0, a} * {32'b0, b};
      2'd2: begin
        // x/0: quotient magnitude all ones, remainder magnitude |rs|; after
        // sign fix-up HI is rs and LO is 1 for negative rs, all ones otherwise.
        if (b == '0) return {a, (a[W-1] ? 32'h0000_0001 : 32'hFFFF_FFFF)};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      default: begin
        if (b == '0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
    endcase
  endfunction

  function automatic int model_latency(input logic [1:0] op, input logic [W-1:0] b);
`ifdef MDU_EARLY_OUT_EN
    logic [W-1:0] mag;
    int k;
    if (!op[1]) begin
      mag = (op == 2'd0 && b[W-1]) ? -b : b;
      k = 1;
      for (int i = 1; i < W; i++) if ((mag >> i) != '0) k = i + 1;
      return k + 1;
    end
`endif
    return W + 1;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_hi = RST_V; m_lo = RST_V; m_busy = 0; m_dz = 1'b0;
      exp_q.delete();
    end else if (flush) begin
      m_busy = 0;
      exp_q.delete();
    end else if (m_busy > 0) begin
      m_busy--;
      if (m_busy == 0) {m_hi, m_lo} = exp_q.pop_front();
    end else if (issue_vld) begin
      exp_q.push_back(model_result(issue_op, rs_val, rt_val));
      m_busy = model_latency(issue_op, rt_val);
      if (issue_op[1]) m_dz = (rt_val == '0);
    end else if (mt_vld) begin
      if (mf_sel) m_hi = mt_data;
      else        m_lo = mt_data;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    logic exp_stall;
    if (started) begin
      exp_stall = (m_busy > 0) && (issue_vld || mf_req || mt_vld);
      check("busy", 64'(busy), 64'(m_busy > 0));
      check("stall", 64'(stall), 64'(exp_stall));
      check("div_zero", 64'(div_zero), 64'(m_dz));
      if (!exp_stall) check("mf_data", 64'(mf_data), 64'(mf_sel ? m_hi : m_lo));
      if (m_busy == 0 && issue_vld && mt_vld) begin
        n_fail++;
        $display("FAIL stim_issue_mt: issue and mt together while idle");
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_issue(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    issue_vld = 1'b1; issue_op = op; rs_val = a; rt_val = b;
    tick();
    issue_vld = 1'b0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy === 1'b1 && n < 200) begin
      n++;
      tick();
    end
  endtask

  task automatic do_mt(input logic sel, input logic [W-1:0] d);
    mt_vld = 1'b1; mf_sel = sel; mt_data = d;
    tick();
    mt_vld = 1'b0; mf_sel = 1'b0;
  endtask

  task automatic read_hilo(input string name, input logic [W-1:0] exp_hi, input logic [W-1:0] exp_lo);
    mf_req = 1'b1;
    mf_sel = 1'b0; #1;
    check({name, "_lo"}, 64'(mf_data), 64'(exp_lo));
    check({name, "_model_lo"}, 64'(m_lo), 64'(exp_lo));
    mf_sel = 1'b1; #1;
    check({name, "_hi"}, 64'(mf_data), 64'(exp_hi));
    check({name, "_model_hi"}, 64'(m_hi), 64'(exp_hi));
    mf_sel = 1'b0;
    mf_req = 1'b0;
  endtask

  // Issue, hold MFLO from accept+1, count busy cycles, then read HI/LO.
  task automatic run_op(input string name, input logic [1:0] op,
                        input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] exp_hi, input logic [W-1:0] exp_lo,
                        input int exp_busy);
    int n;
    do_issue(op, a, b);
    mf_req = 1'b1; mf_sel = 1'b0;
    wait_idle(n);
    check({name, "_busy_cycles"}, 64'(n), 64'(exp_busy));
    check({name, "_stall_released"}, 64'(stall), 64'(0));
    read_hilo(name, exp_hi, exp_lo);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int n;
    rst = 1'b1; issue_vld = 1'b0; issue_op = '0; rs_val = '0; rt_val = '0;
    mf_req = 1'b0; mf_sel = 1'b0; mt_vld = 1'b0; mt_data = '0; flush = 1'b0;
    tick(); tick();
    rst = 1'b0;
    started = 1'b1;
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_div_zero", 64'(div_zero), 64'(0));
    read_hilo("rst", RST_V, RST_V);

    run_op("mult", 2'd0, 32'hFFFF_FFFF, 32'h2, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
    run_op("multu", 2'd1, 32'hFFFF_FFFF, 32'h2, 32'h0000_0001, 32'hFFFF_FFFE, model_latency(2'd1, 32'h2));
    run_op("mult_neg", 2'd0, 32'h0000_0003, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 32'hFFFF_FFF1, model_latency(2'd0, 32'hFFFF_FFFB));
    run_op("div", 2'd2, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 33);
    run_op("divu_zero", 2'd3, 32'h7, 32'h0, 32'h7, 32'hFFFF_FFFF, 33);
    check("div_zero_set", 64'(div_zero), 64'(1));
    run_op("divu_9_3", 2'd3, 32'h9, 32'h3, 32'h0, 32'h3, 33);
    check("div_zero_clear", 64'(div_zero), 64'(0));
    run_op("div_zero_neg", 2'd2, 32'hFFFF_FFF0, 32'h0, 32'hFFFF_FFF0, 32'h0000_0001, 33);

    // MTHI/MTLO then a flushed divide must leave HI/LO alone.
    do_mt(1'b1, 32'h1234_5678);
    do_mt(1'b0, 32'hCAFE_F00D);
    do_issue(2'd2, 32'd100, 32'd7);
    repeat (9) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_busy", 64'(busy), 64'(0));
    read_hilo("flush", 32'h1234_5678, 32'hCAFE_F00D);

    run_op("div_ovf", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 33);

    // Reset in the middle of an op.
    do_issue(2'd1, 32'd3, 32'd5);
    repeat (4) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_busy", 64'(busy), 64'(0));
    read_hilo("midrst", RST_V, RST_V);

    // Held request: second accept lands in the first IDLE cycle after FIX.
    issue_vld = 1'b1; issue_op = 2'd3; rs_val = 32'd100; rt_val = 32'd7;
    repeat (35) tick();
    issue_vld = 1'b0;
    check("b2b_second_accept", 64'(busy), 64'(1));
    wait_idle(n);
    check("b2b_busy_cycles", 64'(n), 64'(33));
    read_hilo("b2b", 32'd2, 32'd14);

`ifdef MDU_EARLY_OUT_EN
    run_op("eo_5x3", 2'd1, 32'd5, 32'd3, 32'd0, 32'd15, 3);
    run_op("eo_5x0", 2'd1, 32'd5, 32'd0, 32'd0, 32'd0, 2);
`else
    run_op("fixed_5x3", 2'd1, 32'd5, 32'd3, 32'd0, 32'd15, 33);
    run_op("fixed_5x0", 2'd1, 32'd5, 32'd0, 32'd0, 32'd0, 33);
`endif

    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1, "timeout");
  end

endmodule
